// File: rtl/spi_slave_param_pkg.sv
// Shared types for the parametrised SPI slave.
// FSM encoding and the two-bit frame command codes.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } spi_state_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_param_shift_out.sv
// MSB-first parallel-load serialiser that owns the MISO register.
// done is high during the last bit cell, so the caller sees the end edge.
module spi_shift_out #(
  parameter int   DATA_W    = 8,
  parameter logic MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              abort,
  input  logic [DATA_W-1:0] din,
  output logic              dout,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sreg;
  logic [CW-1:0]     left;

  assign done = busy && (left == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      left <= '0;
      busy <= 1'b0;
      dout <= MISO_IDLE;
    end else if (abort) begin
      left <= '0;
      busy <= 1'b0;
      dout <= MISO_IDLE;
    end else if (load) begin
      sreg <= din << 1;
      left <= CW'(DATA_W - 1);
      busy <= 1'b1;
      dout <= din[DATA_W-1];
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
        dout <= MISO_IDLE;
      end else begin
        dout <= sreg[DATA_W-1];
        sreg <= sreg << 1;
        left <= left - CW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave front-end: command-tagged frame receive plus
// serialised read-data return on MISO.
module spi_slave_param
  import spi_pkg::*;
#(
  parameter int   DATA_W    = 8,
  parameter logic MISO_IDLE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rd_addr_seen,
  output logic              frame_err
);

  localparam int RX_W = DATA_W + 2;
  localparam int CW   = $clog2(RX_W + 1);

  spi_state_t cs, ns;

  logic [CW-1:0] cnt;
  logic          loaded;
  logic          busy;
  logic          done;

  logic last;
  logic full;
  logic rx_st;
  logic chk_en;
  logic shift_en;
  logic fire;
  logic wait_rd;
  logic load;
  logic rb_end;
  logic err;

  always_comb begin
    ns       = cs;
    last     = (cnt == CW'(RX_W - 1));
    full     = (cnt == CW'(RX_W));
    rx_st    = cs inside {WRITE, READ_ADD, READ_DATA};
    chk_en   = (cs == CHK_CMD) && !SS_n;
    // the final bit still counts when SS_n rises on its edge
    shift_en = rx_st && !full && (!SS_n || last);
    fire     = shift_en && last;
    wait_rd  = (cs == READ_DATA) && full && !loaded;
    load     = wait_rd && tx_valid && !SS_n;
    rb_end   = loaded && (!busy || done);
    err      = SS_n && ((cs == CHK_CMD) ||
               (rx_st && !full && !last) ||
               ((cs == READ_DATA) && full && !rb_end));

    unique case (cs)
      IDLE: begin
        if (!SS_n) ns = CHK_CMD;
      end
      CHK_CMD: begin
        unique case ({MOSI, rd_addr_seen})
          CMD_WR_ADDR: ns = WRITE;
          CMD_WR_DATA: ns = WRITE;
          CMD_RD_ADDR: ns = READ_ADD;
          CMD_RD_DATA: ns = READ_DATA;
        endcase
      end
      WRITE:     ns = WRITE;
      READ_ADD:  ns = READ_ADD;
      READ_DATA: ns = READ_DATA;
      default:   ns = IDLE;
    endcase

    if ((cs != IDLE) && SS_n) ns = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cs <= IDLE;
    else        cs <= ns;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt          <= '0;
      loaded       <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_err    <= 1'b0;
      rd_addr_seen <= 1'b0;
    end else begin
      rx_valid  <= fire;
      frame_err <= err;

      if (cs == IDLE)             cnt <= '0;
      else if (chk_en || shift_en) cnt <= cnt + CW'(1);

      // counter selects the frame bit, MSB first
      for (int i = 0; i < RX_W; i++) begin
        if ((chk_en || shift_en) && (int'(cnt) == RX_W - 1 - i))
          rx_data[i] <= MOSI;
      end

      if (cs == IDLE) loaded <= 1'b0;
      else if (load)  loaded <= 1'b1;

      if (fire && (cs == READ_ADD)) rd_addr_seen <= 1'b1;
      else if (done)                rd_addr_seen <= 1'b0;
    end
  end

  spi_shift_out #(
    .DATA_W    (DATA_W),
    .MISO_IDLE (MISO_IDLE)
  ) u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .abort (SS_n),
    .din   (tx_data),
    .dout  (MISO),
    .busy  (busy),
    .done  (done)
  );

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed bench for spi_slave_param at DATA_W=8 and DATA_W=16.
module tb_spi_slave_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  logic       ss_a, mosi_a, miso_a, rxv_a, txv_a, seen_a, err_a;
  logic [9:0] rxd_a;
  logic [7:0] txd_a;

  logic        ss_b, mosi_b, miso_b, rxv_b, txv_b, seen_b, err_b;
  logic [17:0] rxd_b;
  logic [15:0] txd_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  pat;
  logic [17:0] fb;

  always #5 clk = ~clk;

  spi_slave_param #(.DATA_W(8), .MISO_IDLE(1'b0)) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (ss_a),
    .MOSI         (mosi_a),
    .MISO         (miso_a),
    .rx_data      (rxd_a),
    .rx_valid     (rxv_a),
    .tx_data      (txd_a),
    .tx_valid     (txv_a),
    .rd_addr_seen (seen_a),
    .frame_err    (err_a)
  );

  spi_slave_param #(.DATA_W(16), .MISO_IDLE(1'b0)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .SS_n         (ss_b),
    .MOSI         (mosi_b),
    .MISO         (miso_b),
    .rx_data      (rxd_b),
    .rx_valid     (rxv_b),
    .tx_data      (txd_b),
    .tx_valid     (txv_b),
    .rd_addr_seen (seen_b),
    .frame_err    (err_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    ss_a = 1'b0;
    tick();
  endtask

  task automatic bits_a(input logic [9:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      mosi_a = f[9-i];
      tick();
    end
  endtask

  task automatic end_a();
    ss_a = 1'b1;
    tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    ss_a   = 1'b1; mosi_a = 1'b0; txv_a = 1'b0; txd_a = '0;
    ss_b   = 1'b1; mosi_b = 1'b0; txv_b = 1'b0; txd_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // read address to dirty the state before the mid-frame reset
    start_a();
    bits_a(10'h230, 0, 10);
    chk("rdaddr0_rxd", 32'(rxd_a), 32'h230);
    chk("rdaddr0_seen", 32'(seen_a), 32'd1);
    end_a();

    start_a();
    bits_a(10'h0FF, 0, 4);
    rst_n = 1'b0;
    tick();
    chk("rst_rxd_1st", 32'(rxd_a), 32'h0);
    chk("rst_seen_1st", 32'(seen_a), 32'd0);
    tick(); tick();
    chk("rst_miso", 32'(miso_a), 32'd0);
    chk("rst_rxv", 32'(rxv_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_state", 32'(dut_a.cs), 32'(IDLE));
    ss_a  = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_err", 32'(err_a), 32'd0);

    // write address 00_1010_0101
    start_a();
    bits_a(10'h0A5, 0, 9);
    chk("wa_rxv_e9", 32'(rxv_a), 32'd0);
    bits_a(10'h0A5, 9, 10);
    chk("wa_rxd", 32'(rxd_a), 32'h0A5);
    chk("wa_rxv_e10", 32'(rxv_a), 32'd1);
    chk("wa_err", 32'(err_a), 32'd0);
    mosi_a = 1'b0;
    tick();
    chk("wa_rxv_e11", 32'(rxv_a), 32'd0);
    chk("wa_ignore", 32'(rxd_a), 32'h0A5);
    end_a();
    chk("wa_end_err", 32'(err_a), 32'd0);
    chk("wa_end_state", 32'(dut_a.cs), 32'(IDLE));

    // read address then read data with tx_valid held high
    start_a();
    bits_a(10'h230, 0, 10);
    chk("ra_rxd", 32'(rxd_a), 32'h230);
    chk("ra_seen", 32'(seen_a), 32'd1);
    end_a();

    txd_a = 8'hC3;
    txv_a = 1'b1;
    pat   = 8'hC3;
    start_a();
    bits_a(10'h300, 0, 10);
    chk("rd_rxv", 32'(rxv_a), 32'd1);
    chk("rd_rxd", 32'(rxd_a), 32'h300);
    chk("rd_miso_preload", 32'(miso_a), 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rd_miso_b%0d", 7 - k), 32'(miso_a), 32'(pat[7-k]));
    end
    chk("rd_seen_last", 32'(seen_a), 32'd1);
    tick();
    chk("rd_miso_idle", 32'(miso_a), 32'd0);
    chk("rd_seen_clr", 32'(seen_a), 32'd0);
    tick();
    chk("rd_no_reload", 32'(miso_a), 32'd0);
    txv_a = 1'b0;
    end_a();
    chk("rd_end_err", 32'(err_a), 32'd0);

    // abort a write frame after five bits while rd_addr_seen is set
    start_a();
    bits_a(10'h2A5, 0, 10);
    end_a();
    start_a();
    bits_a(10'h0AA, 0, 5);
    end_a();
    chk("ab_err", 32'(err_a), 32'd1);
    chk("ab_rxv", 32'(rxv_a), 32'd0);
    chk("ab_state", 32'(dut_a.cs), 32'(IDLE));
    chk("ab_seen", 32'(seen_a), 32'd1);
    tick();
    chk("ab_err_once", 32'(err_a), 32'd0);

    // delayed tx_valid on a read-data frame
    txd_a = 8'h96;
    pat   = 8'h96;
    start_a();
    bits_a(10'h300, 0, 10);
    chk("dl_rxv", 32'(rxv_a), 32'd1);
    for (int w = 0; w < 6; w++) begin
      tick();
      chk($sformatf("dl_wait%0d", w), 32'(miso_a), 32'd0);
    end
    txv_a = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      txv_a = 1'b0;
      chk($sformatf("dl_miso_b%0d", 7 - k), 32'(miso_a), 32'(pat[7-k]));
    end
    chk("dl_seen_last", 32'(seen_a), 32'd1);
    tick();
    chk("dl_miso_idle", 32'(miso_a), 32'd0);
    chk("dl_seen_clr", 32'(seen_a), 32'd0);
    end_a();

    // SS_n rises on the edge of the last frame bit
    start_a();
    bits_a(10'h15A, 0, 9);
    mosi_a = 1'b0;
    ss_a   = 1'b1;
    tick();
    chk("lr_rxd", 32'(rxd_a), 32'h15A);
    chk("lr_rxv", 32'(rxv_a), 32'd1);
    chk("lr_err", 32'(err_a), 32'd0);
    chk("lr_state", 32'(dut_a.cs), 32'(IDLE));
    tick();
    chk("lr_err_after", 32'(err_a), 32'd0);

    // abort mid-readback
    start_a();
    bits_a(10'h2F0, 0, 10);
    end_a();
    txd_a = 8'hF0;
    txv_a = 1'b1;
    start_a();
    bits_a(10'h300, 0, 10);
    tick(); tick(); tick();
    chk("mr_miso_b5", 32'(miso_a), 32'd1);
    txv_a = 1'b0;
    end_a();
    chk("mr_err", 32'(err_a), 32'd1);
    chk("mr_miso", 32'(miso_a), 32'd0);
    chk("mr_seen", 32'(seen_a), 32'd1);

    // wide instance: write data 01 + BEEF
    fb   = 18'h1BEEF;
    ss_b = 1'b0;
    tick();
    for (int i = 0; i < 18; i++) begin
      mosi_b = fb[17-i];
      tick();
      if (i == 16) chk("w_rxv_e17", 32'(rxv_b), 32'd0);
    end
    chk("w_rxd", 32'(rxd_b), 32'h1BEEF);
    chk("w_rxv_e18", 32'(rxv_b), 32'd1);
    ss_b = 1'b1;
    tick();
    chk("w_rxv_off", 32'(rxv_b), 32'd0);
    chk("w_err", 32'(err_b), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
